// File: rtl/led_cmd_sched_if.sv
// Frame-level link between spi_slave and the LED command scheduler:
// decoded rx frame strobe plus the response frame tx handshake.
interface led_cmd_sched_if #(
  parameter int CMD_W     = 8,
  parameter int ADDR_W    = 8,
  parameter int PAYLOAD_W = 8
);
  logic                              i_rx_dv;
  logic [CMD_W-1:0]                  i_cmd;
  logic [ADDR_W-1:0]                 i_addr;
  logic [PAYLOAD_W-1:0]              i_payload;
  logic                              i_tx_ack;
  logic                              o_tx_enb;
  logic [CMD_W+ADDR_W+PAYLOAD_W-1:0] o_slv_frame;

  modport master (
    output i_rx_dv, i_cmd, i_addr, i_payload, i_tx_ack,
    input  o_tx_enb, o_slv_frame
  );

  modport slave (
    input  i_rx_dv, i_cmd, i_addr, i_payload, i_tx_ack,
    output o_tx_enb, o_slv_frame
  );
endinterface

// File: rtl/led_cmd_sched.sv
// Queues decoded SPI frames and executes them one at a time against the LED
// brightness register file; LED_READ responses go back through a tx handshake.
module led_cmd_sched #(
  parameter int         CMD_W        = 8,
  parameter int         ADDR_W       = 8,
  parameter int         PAYLOAD_W    = 8,
  parameter int         NUM_LEDS     = 8,
  parameter int         FIFO_DEPTH   = 4,
  parameter int         TX_TIMEOUT   = 1000,
  parameter int         BRIGHT_MAX   = 100,
  parameter logic [7:0] CMD_NOP      = 8'h00,
  parameter logic [7:0] CMD_LED_SET  = 8'h01,
  parameter logic [7:0] CMD_LED_READ = 8'h02
) (
  input  logic                  sysclk,
  input  logic                  rst,
  led_cmd_sched_if.slave        bus,
  output logic [NUM_LEDS*7-1:0] o_brightness,
  output logic                  o_busy,
  output logic [7:0]            o_drop_cnt,
  output logic [7:0]            o_err_cnt
);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int IDX_W   = $clog2(NUM_LEDS);
  localparam int TMR_W   = $clog2(TX_TIMEOUT) + 1;
  localparam int ENTRY_W = CMD_W + ADDR_W + 7;
  localparam logic [ADDR_W-1:0] LED_LIMIT  = ADDR_W'(NUM_LEDS);
  localparam logic [TMR_W-1:0]  TMR_LAST   = TMR_W'(TX_TIMEOUT - 1);
  localparam logic [6:0]        BRIGHT_CAP = 7'(BRIGHT_MAX);
  localparam logic [PTR_W:0]    FIFO_FULL  = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXEC    = 2'd1,
    S_TX_WAIT = 2'd2
  } state_t;

  state_t r_state, w_next;

  logic [ENTRY_W-1:0] r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]     r_count;
  logic [CMD_W-1:0]   r_cmd;
  logic [ADDR_W-1:0]  r_addr;
  logic [6:0]         r_req_bright;
  logic [6:0]         r_bright [NUM_LEDS];
  logic [TMR_W-1:0]   r_timer;
  logic               r_tx_enb;
  logic [CMD_W+ADDR_W+PAYLOAD_W-1:0] r_slv_frame;
  logic [7:0]         r_drop_cnt, r_err_cnt;

  logic w_full, w_empty, w_push, w_drop, w_pop, w_addr_ok;
  logic w_set_wr, w_rd_start, w_tx_clear, w_err_inc, w_tmr_inc;
  logic [IDX_W-1:0] w_idx;
  logic [6:0]       w_set_val;

  // Full is judged on the pre-edge occupancy, so a simultaneous pop cannot rescue a push.
  assign w_full    = (r_count == FIFO_FULL);
  assign w_empty   = (r_count == '0);
  assign w_push    = bus.i_rx_dv && !w_full;
  assign w_drop    = bus.i_rx_dv && w_full;
  assign w_addr_ok = (r_addr < LED_LIMIT);
  assign w_idx     = r_addr[IDX_W-1:0];
  assign w_set_val = (r_req_bright > BRIGHT_CAP) ? BRIGHT_CAP : r_req_bright;

  assign o_busy          = (r_state != S_IDLE) || !w_empty;
  assign o_drop_cnt      = r_drop_cnt;
  assign o_err_cnt       = r_err_cnt;
  assign bus.o_tx_enb    = r_tx_enb;
  assign bus.o_slv_frame = r_slv_frame;

  // Flatten the brightness register file onto the output bus.
  always_comb begin
    o_brightness = '0;
    for (int k = 0; k < NUM_LEDS; k++) begin
      o_brightness[7*k +: 7] = r_bright[k];
    end
  end

  // FSM state register.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and per-cycle action strobes.
  always_comb begin
    w_next     = r_state;
    w_pop      = 1'b0;
    w_set_wr   = 1'b0;
    w_rd_start = 1'b0;
    w_tx_clear = 1'b0;
    w_err_inc  = 1'b0;
    w_tmr_inc  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = S_EXEC;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_EXEC: begin
        w_next = S_IDLE;
        case (r_cmd)
          CMD_W'(CMD_NOP): w_next = S_IDLE;
          CMD_W'(CMD_LED_SET): begin
            if (w_addr_ok) begin
              w_set_wr = 1'b1;
            end else begin
              w_err_inc = 1'b1;
            end
          end
          CMD_W'(CMD_LED_READ): begin
            if (w_addr_ok) begin
              w_rd_start = 1'b1;
              w_next     = S_TX_WAIT;
            end else begin
              w_err_inc = 1'b1;
            end
          end
          default: w_err_inc = 1'b1;
        endcase
      end
      S_TX_WAIT: begin
        if (bus.i_tx_ack) begin
          w_tx_clear = 1'b1;
          w_next     = S_IDLE;
        end else if (r_timer == TMR_LAST) begin
          w_tx_clear = 1'b1;
          w_err_inc  = 1'b1;
          w_next     = S_IDLE;
        end else begin
          w_tmr_inc = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Frame storage; payload bit 0 never reaches the brightness path, so it is not kept.
  always_ff @(posedge sysclk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= {bus.i_cmd, bus.i_addr, bus.i_payload[7:1]};
    end
  end

  // Queue pointers, occupancy and the popped command registers.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_cmd        <= '0;
      r_addr       <= '0;
      r_req_bright <= 7'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        {r_cmd, r_addr, r_req_bright} <= r_fifo[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Command execution: brightness writes, response frame, tx timer, debug counters.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_LEDS; k++) begin
        r_bright[k] <= 7'd0;
      end
      r_timer     <= '0;
      r_tx_enb    <= 1'b0;
      r_slv_frame <= '0;
      r_drop_cnt  <= 8'd0;
      r_err_cnt   <= 8'd0;
    end else begin
      if (w_set_wr) begin
        r_bright[w_idx] <= w_set_val;
      end
      if (w_rd_start) begin
        r_slv_frame <= {CMD_W'(CMD_LED_READ), r_addr, PAYLOAD_W'({r_bright[w_idx], 1'b0})};
        r_tx_enb    <= 1'b1;
        r_timer     <= '0;
      end else if (w_tx_clear) begin
        r_tx_enb <= 1'b0;
      end else if (w_tmr_inc) begin
        r_timer <= r_timer + TMR_W'(1);
      end
      if (w_drop && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
      if (w_err_inc && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end
endmodule
